// File: rtl/nonrestoring_divider_seq.sv
// Sequential unsigned non-restoring divider: one add/subtract step per clock,
// then a single remainder-correction cycle, behind a start/done handshake.
module nonrestoring_divider_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_CORR, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH:0]   m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   a_sh, a_step, a_fix;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;

      a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      a_step = a_q[WIDTH] ? (a_sh + m_q) : (a_sh + ~m_q + ONE);
      a_fix  = a_q + m_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               q_d = dividend;
               if (divisor == '0) begin
                  // Divide-by-zero spends one busy cycle so the result lands in
                  // the same place in the handshake as a normal division.
                  m_d     = '0;
                  state_d = S_LOAD;
               end else begin
                  a_d     = '0;
                  m_d     = {1'b0, divisor};
                  cnt_d   = CW'(WIDTH);
                  state_d = S_ITER;
               end
            end
         end
         S_LOAD: begin
            quot_d  = '1;
            rem_d   = q_q;
            dz_d    = 1'b1;
            state_d = S_DONE;
         end
         S_ITER: begin
            a_d   = a_step;
            q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = S_CORR;
         end
         S_CORR: begin
            // A negative final partial remainder is restored by adding M back once.
            a_d     = a_q[WIDTH] ? a_fix : a_q;
            quot_d  = q_q;
            rem_d   = a_q[WIDTH] ? a_fix[WIDTH-1:0] : a_q[WIDTH-1:0];
            dz_d    = 1'b0;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_LOAD) || (state_d == S_ITER) || (state_d == S_CORR);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dz_q;
endmodule
